regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the single register-file write port between NUM_REQ writeback sources: 0=core ALU, 1=load unit, 2=IO/debug loader.
//  Round-robin arbitration with optional burst lock and a registered output stage that drives the register file's
//  write_data/rd/reg_write inputs. Sits between the writeback sources and the register file.
// PARAMETERS
//  NUM_REQ   3   number of requesters (1..8)
//  MAX_LOCK  16  max consecutive locked grants to one owner before forced release (>=1)
// PORTS
//  clk         in   1          core clock; all state changes on posedge
//  reset       in   1          asynchronous, active-low reset
//  req_valid   in   NUM_REQ    requester i has a write pending
//  req_lock    in   NUM_REQ    requester i asks to keep the grant (burst)
//  req_rd      in   5*NUM_REQ  dest reg of requester i, bits [5i+4:5i]
//  req_data    in   32*NUM_REQ write value of requester i, bits [32i+31:32i]
//  req_ready   out  NUM_REQ    one-hot grant; transfer when valid&ready at posedge
//  freeze      in   1          pipeline stall; no grants while high
//  write_data  out  1          register-file write enable
//  rd          out  5          register-file write address
//  reg_write   out  32         register-file write value
//  grant_id    out  $clog2(NUM_REQ) (min 1)  index of last accepted requester
//  locked      out  1          burst lock currently held
// BEHAVIOUR
//  - Reset (async, reset=0): write_data=0, rd=0, reg_write=0, grant_id=0, locked=0, rr pointer=0, lock count=0.
//  - req_ready combinational: freeze=1 -> all 0. Locked -> only owner bit. Otherwise first valid index
//    searching from rr pointer upward with wrap. No valid -> all 0. At most one bit set.
//  - Accept = req_valid[i]&req_ready[i] at posedge. Latency 1: next cycle write_data=(req_rd!=0), rd/reg_write=captured
//    values, grant_id=i. Register file commits at the following negedge.
//  - rd=0 requests are accepted (ready honoured) but produce write_data=0; rd/reg_write still update.
//  - No accept: write_data=0 next cycle; rd, reg_write, grant_id hold. write_data never high two cycles from one accept.
//  - RR pointer: after an unlocked accept from i, pointer=(i+1) mod NUM_REQ. Otherwise it holds.
//  - Lock FSM: IDLE -> LOCKED when accept from i with req_lock[i]=1 (owner=i, count=1).
//    LOCKED: each owner accept increments count. Exit to IDLE when owner's req_lock=0 at posedge,
//    or owner accept with count==MAX_LOCK. On exit, pointer=(owner+1) mod NUM_REQ.
//    Owner req_valid=0 while locked: no grant to anyone, lock held (bounded by req_lock).
//  - freeze=1: no accepts; pointer, lock state, count hold; write_data=0 next cycle.
//  - NUM_REQ=1: pointer fixed at 0; lock still counts and releases.
//  - Reset mid-burst: lock dropped, a pending write_data pulse cleared immediately.
// CONFIGURATION
//  RF_BYPASS_EN defined: extra ports byp_rs1,byp_rs2 (in,5), byp_hit1,byp_hit2 (out,1), byp_data1,byp_data2 (out,32).
//    hitN = write_data & (rd==byp_rsN) & (byp_rsN!=0). byp_dataN = reg_write. Combinational. Lets readers see the
//    value before the negedge commit.
//  Not defined: ports absent; no bypass logic.
// STRUCTURE
//  Shared package: requester index constants (REQ_ALU=0, REQ_LOAD=1, REQ_IO=2), RF_ADDR_W=5, RF_DATA_W=32,
//  lock FSM state typedef {IDLE, LOCKED}.
//  One sub-module: rr_pick (pointer + valid mask -> one-hot grant). Lock FSM and output stage stay in top.
// TESTING
//  1. Reset low with all valid -> all outputs 0, req_ready=0. Release: first grant = req0.
//  2. All three valid, no lock, rd=1/2/3 -> grants 0,1,2,0; write_data each cycle, rd follows 1,2,3.
//  3. req2 lock=1 held, MAX_LOCK=4, others valid -> 4 consecutive req2 grants. Then grant req0; locked drops.
//  4. req1 valid, rd=0, data=0xDEAD -> ready=1, accepted, write_data stays 0, reg_write=0xDEAD.
//  5. freeze=1 for 3 cycles with requests pending -> req_ready=0, write_data=0, pointer unchanged after release.
//  6. RF_BYPASS_EN: accept rd=5 data=0x1234, byp_rs1=5 -> byp_hit1=1, byp_data1=0x1234. byp_rs2=0 -> byp_hit2=0.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: requester indices,
// register-file widths and the burst-lock state encoding.
package regfile_write_arbiter_pkg;

   localparam int REQ_ALU  = 0;
   localparam int REQ_LOAD = 1;
   localparam int REQ_IO   = 2;

   localparam int RF_ADDR_W = 5;
   localparam int RF_DATA_W = 32;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } lock_state_e;

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Round-robin picker: the first valid requester at or above the pointer,
// wrapping around. The output is one-hot, or all zero when nothing is valid.
module regfile_write_arbiter_rr_pick #(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = 2
) (
   input  logic [PTR_W-1:0]   ptr,
   input  logic [NUM_REQ-1:0] valid,
   output logic [NUM_REQ-1:0] grant
);

   logic found;

   // Walk the offsets from the pointer and take the first valid slot.
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int off = 0; off < NUM_REQ; off++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && valid[i] && (i == ((int'(ptr) + off) % NUM_REQ))) begin
               grant[i] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter. It runs round-robin arbitration between the
// writeback sources, with an optional burst lock and a registered output stage.
// Optional feature macro RF_BYPASS_EN adds combinational read-bypass ports.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = 3,
   parameter int MAX_LOCK = 16,
   localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0]             req_lock,
   input  logic [RF_ADDR_W*NUM_REQ-1:0]   req_rd,
   input  logic [RF_DATA_W*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic                           freeze,
   output logic                           write_data,
   output logic [RF_ADDR_W-1:0]           rd,
   output logic [RF_DATA_W-1:0]           reg_write,
   output logic [PTR_W-1:0]               grant_id,
   output logic                           locked
`ifdef RF_BYPASS_EN
  ,input  logic [RF_ADDR_W-1:0]           byp_rs1,
   input  logic [RF_ADDR_W-1:0]           byp_rs2,
   output logic                           byp_hit1,
   output logic                           byp_hit2,
   output logic [RF_DATA_W-1:0]           byp_data1,
   output logic [RF_DATA_W-1:0]           byp_data2
`endif
);

   localparam int CNT_W = $clog2(MAX_LOCK + 1);

   lock_state_e           lock_state_q, lock_state_d;
   logic [PTR_W-1:0]      owner_q, owner_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic                  write_data_q, write_data_d;
   logic [RF_ADDR_W-1:0]  rd_q, rd_d;
   logic [RF_DATA_W-1:0]  reg_write_q, reg_write_d;
   logic [PTR_W-1:0]      grant_id_q, grant_id_d;

   logic [NUM_REQ-1:0]    rr_grant;
   logic [NUM_REQ-1:0]    owner_oh;
   logic                  owner_lock;
   logic                  acc;
   logic [PTR_W-1:0]      acc_idx;
   logic                  acc_lock;
   logic [RF_ADDR_W-1:0]  acc_rd;
   logic [RF_DATA_W-1:0]  acc_data;
   logic [CNT_W-1:0]      cnt_inc;

   // Advance an index by one, wrapping at NUM_REQ.
   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
      return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
   endfunction

   regfile_write_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_pick (
      .ptr   (ptr_q),
      .valid (req_valid),
      .grant (rr_grant)
   );

   // Owner one-hot and its lock request, used while a burst is held.
   always_comb begin
      owner_oh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         owner_oh[i] = (owner_q == PTR_W'(i));
      end
      owner_lock = |(owner_oh & req_lock);
   end

   // Grant: masked by reset and freeze. Pinned to the owner while locked, otherwise round-robin.
   always_comb begin
      req_ready = '0;
      if (reset && !freeze) begin
         if (lock_state_q == LOCKED) req_ready = owner_oh & req_valid;
         else                        req_ready = rr_grant;
      end
   end

   // Decode the accepted requester and mux its payload.
   always_comb begin
      acc      = |(req_valid & req_ready);
      acc_idx  = '0;
      acc_lock = 1'b0;
      acc_rd   = '0;
      acc_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            acc_idx  = PTR_W'(i);
            acc_lock = req_lock[i];
            acc_rd   = req_rd[i*RF_ADDR_W +: RF_ADDR_W];
            acc_data = req_data[i*RF_DATA_W +: RF_DATA_W];
         end
      end
   end

   // Next-state logic for the lock FSM and the round-robin pointer.
   always_comb begin
      lock_state_d = lock_state_q;
      owner_d      = owner_q;
      cnt_d        = cnt_q;
      ptr_d        = ptr_q;
      cnt_inc      = cnt_q + 1'b1;
      if (!freeze) begin
         if (lock_state_q == IDLE) begin
            if (acc) begin
               // A lock of 1 is just a single grant, so it never enters LOCKED.
               if (acc_lock && MAX_LOCK > 1) begin
                  lock_state_d = LOCKED;
                  owner_d      = acc_idx;
                  cnt_d        = CNT_W'(1);
               end else begin
                  ptr_d = wrap_inc(acc_idx);
               end
            end
         end else begin
            // Leave the burst when the owner stops asking, or when its last allowed grant is taken.
            if (!owner_lock || (acc && cnt_inc == CNT_W'(MAX_LOCK))) begin
               lock_state_d = IDLE;
               cnt_d        = '0;
               ptr_d        = wrap_inc(owner_q);
            end else if (acc) begin
               cnt_d = cnt_inc;
            end
         end
      end
   end

   // Output stage: capture the accepted write. A no-accept cycle only drops the enable.
   always_comb begin
      write_data_d = 1'b0;
      rd_d         = rd_q;
      reg_write_d  = reg_write_q;
      grant_id_d   = grant_id_q;
      if (acc) begin
         write_data_d = (acc_rd != '0);
         rd_d         = acc_rd;
         reg_write_d  = acc_data;
         grant_id_d   = acc_idx;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lock_state_q <= IDLE;
         owner_q      <= '0;
         cnt_q        <= '0;
         ptr_q        <= '0;
         write_data_q <= 1'b0;
         rd_q         <= '0;
         reg_write_q  <= '0;
         grant_id_q   <= '0;
      end else begin
         lock_state_q <= lock_state_d;
         owner_q      <= owner_d;
         cnt_q        <= cnt_d;
         ptr_q        <= ptr_d;
         write_data_q <= write_data_d;
         rd_q         <= rd_d;
         reg_write_q  <= reg_write_d;
         grant_id_q   <= grant_id_d;
      end
   end

   assign write_data = write_data_q;
   assign rd         = rd_q;
   assign reg_write  = reg_write_q;
   assign grant_id   = grant_id_q;
   assign locked     = (lock_state_q == LOCKED);

`ifdef RF_BYPASS_EN
   // Readers see the pending write before it commits to the register file.
   always_comb begin
      byp_hit1  = write_data_q && (rd_q == byp_rs1) && (byp_rs1 != '0);
      byp_hit2  = write_data_q && (rd_q == byp_rs2) && (byp_rs2 != '0);
      byp_data1 = reg_write_q;
      byp_data2 = reg_write_q;
   end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

   logic        clk;
   logic        reset;
   logic [2:0]  req_valid;
   logic [2:0]  req_lock;
   logic [14:0] req_rd;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        freeze;
   logic        write_data;
   logic [4:0]  rd;
   logic [31:0] reg_write;
   logic [1:0]  grant_id;
   logic        locked;
`ifdef RF_BYPASS_EN
   logic [4:0]  byp_rs1, byp_rs2;
   logic        byp_hit1, byp_hit2;
   logic [31:0] byp_data1, byp_data2;
`endif

   int checks   = 0;
   int failures = 0;

   regfile_write_arbiter #(.NUM_REQ(3), .MAX_LOCK(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_lock   (req_lock),
      .req_rd     (req_rd),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .freeze     (freeze),
      .write_data (write_data),
      .rd         (rd),
      .reg_write  (reg_write),
      .grant_id   (grant_id),
      .locked     (locked)
`ifdef RF_BYPASS_EN
     ,.byp_rs1    (byp_rs1),
      .byp_rs2    (byp_rs2),
      .byp_hit1   (byp_hit1),
      .byp_hit2   (byp_hit2),
      .byp_data1  (byp_data1),
      .byp_data2  (byp_data2)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
      req_rd[i*5 +: 5]    = r;
      req_data[i*32 +: 32] = d;
   endtask

   initial begin
      logic [4:0] exp_rd [4];
      logic [1:0] exp_gid [4];
      exp_rd  = '{5'd1, 5'd2, 5'd3, 5'd1};
      exp_gid = '{2'd0, 2'd1, 2'd2, 2'd0};

      // 1: reset with all requesters valid
      reset     = 1'b0;
      freeze    = 1'b0;
      req_valid = 3'b111;
      req_lock  = 3'b000;
      req_rd    = '0;
      req_data  = '0;
      set_req(0, 5'd1, 32'hA000_0000);
      set_req(1, 5'd2, 32'hA000_0001);
      set_req(2, 5'd3, 32'hA000_0002);
`ifdef RF_BYPASS_EN
      byp_rs1 = '0;
      byp_rs2 = '0;
`endif
      #2;
      chk("rst_wd",    32'(write_data), 32'd0);
      chk("rst_rd",    32'(rd),         32'd0);
      chk("rst_rw",    reg_write,       32'd0);
      chk("rst_gid",   32'(grant_id),   32'd0);
      chk("rst_lock",  32'(locked),     32'd0);
      chk("rst_ready", 32'(req_ready),  32'd0);
      tick();
      reset = 1'b1;
      #1;
      chk("rel_ready", 32'(req_ready), 32'b001);

      // 2: plain round-robin over all three
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rr_wd",  32'(write_data), 32'd1);
         chk("rr_rd",  32'(rd),         32'(exp_rd[k]));
         chk("rr_gid", 32'(grant_id),   32'(exp_gid[k]));
         chk("rr_rw",  reg_write,       32'hA000_0000 + 32'(exp_gid[k]));
      end

      // 4: rd=0 write is accepted without raising the enable
      req_valid = 3'b010;
      set_req(1, 5'd0, 32'h0000_DEAD);
      #1;
      chk("rd0_ready", 32'(req_ready), 32'b010);
      tick();
      chk("rd0_wd",  32'(write_data), 32'd0);
      chk("rd0_rd",  32'(rd),         32'd0);
      chk("rd0_rw",  reg_write,       32'h0000_DEAD);
      chk("rd0_gid", 32'(grant_id),   32'd1);

      // 5: freeze blocks grants and holds the pointer (now at 2)
      set_req(1, 5'd2, 32'hA000_0001);
      req_valid = 3'b111;
      freeze    = 1'b1;
      #1;
      chk("frz_ready", 32'(req_ready), 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("frz_wd",    32'(write_data), 32'd0);
         chk("frz_rw",    reg_write,       32'h0000_DEAD);
         chk("frz_ready", 32'(req_ready),  32'd0);
      end
      freeze = 1'b0;
      #1;
      chk("unfrz_ready", 32'(req_ready), 32'b100);
      tick();
      chk("unfrz_gid", 32'(grant_id),   32'd2);
      chk("unfrz_rd",  32'(rd),         32'd3);
      chk("unfrz_wd",  32'(write_data), 32'd1);

      // 3: req2 burst, MAX_LOCK=4 gives four grants then a release to req0
      req_valid = 3'b100;
      req_lock  = 3'b100;
      #1;
      chk("lk_ready0", 32'(req_ready), 32'b100);
      tick();
      chk("lk_gid1",  32'(grant_id), 32'd2);
      chk("lk_lock1", 32'(locked),   32'd1);
      req_valid = 3'b111;
      #1;
      chk("lk_ready1", 32'(req_ready), 32'b100);
      for (int k = 2; k <= 4; k++) begin
         tick();
         chk("lk_gid",  32'(grant_id),   32'd2);
         chk("lk_wd",   32'(write_data), 32'd1);
         chk("lk_lock", 32'(locked),     (k < 4) ? 32'd1 : 32'd0);
      end
      chk("lk_rel_ready", 32'(req_ready), 32'b001);
      tick();
      chk("lk_rel_gid",  32'(grant_id), 32'd0);
      chk("lk_rel_lock", 32'(locked),   32'd0);

      // Lock released by the owner dropping req_lock (pointer now 1)
      req_valid = 3'b010;
      req_lock  = 3'b010;
      tick();
      chk("drop_gid",  32'(grant_id), 32'd1);
      chk("drop_lock", 32'(locked),   32'd1);
      req_lock  = 3'b000;
      req_valid = 3'b111;
      #1;
      chk("drop_ready", 32'(req_ready), 32'b010);
      tick();
      chk("drop_gid2",  32'(grant_id), 32'd1);
      chk("drop_lock2", 32'(locked),   32'd0);
      chk("drop_ready2", 32'(req_ready), 32'b100);

      // Owner goes invalid while locked: nobody is granted, lock is held
      req_valid = 3'b100;
      req_lock  = 3'b100;
      tick();
      chk("inv_lock", 32'(locked), 32'd1);
      req_valid = 3'b011;
      #1;
      chk("inv_ready", 32'(req_ready), 32'b000);
      tick();
      chk("inv_wd",    32'(write_data), 32'd0);
      chk("inv_lock2", 32'(locked),     32'd1);
      req_valid = 3'b100;
      tick();
      chk("inv_wd2", 32'(write_data), 32'd1);

      // Reset mid-burst clears lock and pending enable immediately
      reset = 1'b0;
      #1;
      chk("mrst_wd",    32'(write_data), 32'd0);
      chk("mrst_lock",  32'(locked),     32'd0);
      chk("mrst_rd",    32'(rd),         32'd0);
      chk("mrst_ready", 32'(req_ready),  32'd0);

`ifdef RF_BYPASS_EN
      // 6: bypass of a pending write
      tick();
      reset     = 1'b1;
      req_lock  = 3'b000;
      req_valid = 3'b001;
      set_req(0, 5'd5, 32'h0000_1234);
      byp_rs1 = 5'd5;
      byp_rs2 = 5'd0;
      tick();
      chk("byp_hit1",  32'(byp_hit1), 32'd1);
      chk("byp_data1", byp_data1,     32'h0000_1234);
      chk("byp_hit2",  32'(byp_hit2), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
